// File: rtl/am_modulator.sv
// AM modulator: y = sat((CARRIER_OFFSET + msg) * cos_table[phase] >>> 32), Q32.32 signed.
// One sample in flight; IDLE captures, CALC registers the result, HOLD waits for y_ready.
module am_modulator #(
   parameter logic [63:0] CARRIER_OFFSET = 64'h00000001_00000000,
   parameter logic [3:0]  PHASE_STEP     = 4'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] msg_data,
   input  logic        msg_valid,
   output logic        msg_ready,
   output logic [63:0] y,
   output logic        y_valid,
   input  logic        y_ready,
   output logic [3:0]  phase,
   output logic        sat
);

   localparam logic [1:0] st_idle = 2'd0;
   localparam logic [1:0] st_calc = 2'd1;
   localparam logic [1:0] st_hold = 2'd2;

   logic [1:0]   state_q;
   logic [63:0]  msg_q;
   logic [63:0]  y_q;
   logic         sat_q;
   logic [3:0]   phase_q;

   logic [63:0]  carrier;
   logic [64:0]  sum;
   logic [128:0] prod;
   logic         pos_ovf;
   logic         neg_ovf;
   logic [63:0]  y_calc;
   logic         unused_prod;

   // cos(2*pi*k/16) in Q32.32, rounded to nearest
   always_comb begin
      carrier = 64'h0;
      case (phase_q)
         4'd0:    carrier = 64'h00000001_00000000;
         4'd1:    carrier = 64'h00000000_EC835E7A;
         4'd2:    carrier = 64'h00000000_B504F334;
         4'd3:    carrier = 64'h00000000_61F78A9B;
         4'd4:    carrier = 64'h00000000_00000000;
         4'd5:    carrier = 64'hFFFFFFFF_9E087565;
         4'd6:    carrier = 64'hFFFFFFFF_4AFB0CCC;
         4'd7:    carrier = 64'hFFFFFFFF_137CA186;
         4'd8:    carrier = 64'hFFFFFFFF_00000000;
         4'd9:    carrier = 64'hFFFFFFFF_137CA186;
         4'd10:   carrier = 64'hFFFFFFFF_4AFB0CCC;
         4'd11:   carrier = 64'hFFFFFFFF_9E087565;
         4'd12:   carrier = 64'h00000000_00000000;
         4'd13:   carrier = 64'h00000000_61F78A9B;
         4'd14:   carrier = 64'h00000000_B504F334;
         default: carrier = 64'h00000000_EC835E7A;
      endcase
   end

   // Sign-extended operands make the unsigned 129-bit product the exact signed product.
   assign sum  = {msg_q[63], msg_q} + {CARRIER_OFFSET[63], CARRIER_OFFSET};
   assign prod = {{64{sum[64]}}, sum} * {{65{carrier[63]}}, carrier};

   // prod[128:32] is the shifted result; it fits 64 bits only if bits 128..95 agree.
   assign pos_ovf = !prod[128] && (|prod[127:95]);
   assign neg_ovf = prod[128] && !(&prod[127:95]);

   always_comb begin
      y_calc = prod[95:32];
      if (pos_ovf) begin
         y_calc = 64'h7FFFFFFF_FFFFFFFF;
      end else if (neg_ovf) begin
         y_calc = 64'h80000000_00000000;
      end
   end

   assign unused_prod = ^prod[31:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= st_idle;
         msg_q   <= 64'h0;
         y_q     <= 64'h0;
         sat_q   <= 1'b0;
         phase_q <= 4'd0;
      end else begin
         case (state_q)
            st_idle: begin
               if (msg_valid) begin
                  msg_q   <= msg_data;
                  state_q <= st_calc;
               end
            end
            st_calc: begin
               y_q     <= y_calc;
               sat_q   <= pos_ovf | neg_ovf;
               state_q <= st_hold;
            end
            st_hold: begin
               if (y_ready) begin
                  phase_q <= phase_q + PHASE_STEP;
                  state_q <= st_idle;
               end
            end
            default: state_q <= st_idle;
         endcase
      end
   end

   assign msg_ready = rst && (state_q == st_idle);
   assign y_valid   = (state_q == st_hold);
   assign y         = y_q;
   assign sat       = sat_q;
   assign phase     = phase_q;

endmodule

// File: tb/tb_am_modulator.sv
// Bench for am_modulator: random and directed samples, expected results queued from a
// cosine/arithmetic model and compared by an independent output monitor.
module tb_am_modulator;

   localparam logic [63:0] OFFSET = 64'h00000001_00000000;
   localparam int          STEP   = 1;
   localparam logic signed [127:0] MAXV = 128'sh7FFFFFFF_FFFFFFFF;
   localparam logic signed [127:0] MINV = -128'sh80000000_00000000;

   typedef struct packed {
      logic [63:0] y;
      logic        sat;
      logic [3:0]  ph;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] msg_data = 64'h0;
   logic        msg_valid = 1'b0;
   logic        msg_ready;
   logic [63:0] y;
   logic        y_valid;
   logic        y_ready = 1'b0;
   logic [3:0]  phase;
   logic        sat;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   exp_phase = 0;
   bit   rand_ready = 1'b0;

   am_modulator #(
      .CARRIER_OFFSET(OFFSET),
      .PHASE_STEP    (4'(STEP))
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .msg_data (msg_data),
      .msg_valid(msg_valid),
      .msg_ready(msg_ready),
      .y        (y),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .phase    (phase),
      .sat      (sat)
   );

   always #5 clk = ~clk;

   function automatic longint carrier(input int k);
      real r;
      r = $cos(2.0 * 3.14159265358979323846 * real'(k) / 16.0) * 4294967296.0;
      return longint'($floor(r + 0.5));
   endfunction

   function automatic exp_t model(input logic [63:0] m, input int k);
      logic signed [127:0] s, c, p, q;
      longint cv;
      exp_t e;
      cv = carrier(k);
      s = $signed({{64{m[63]}}, m}) + $signed({{64{OFFSET[63]}}, OFFSET});
      c = 128'(cv);
      p = s * c;
      q = p >>> 32;
      e.ph = 4'(k);
      if (q > MAXV) begin
         e.y = 64'h7FFFFFFF_FFFFFFFF;
         e.sat = 1'b1;
      end else if (q < MINV) begin
         e.y = 64'h80000000_00000000;
         e.sat = 1'b1;
      end else begin
         e.y = q[63:0];
         e.sat = 1'b0;
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every cycle y is presented it must match the head of the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && y_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: y=%h with empty scoreboard", y);
            end else begin
               check("y", y, exp_q[0].y);
               check("sat", 64'(sat), 64'(exp_q[0].sat));
               check("phase", 64'(phase), 64'(exp_q[0].ph));
               check("msg_ready_in_hold", 64'(msg_ready), 64'(0));
               if (y_ready === 1'b1) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rand_ready) y_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      msg_valid = 1'b0;
      exp_q.delete();
      exp_phase = 0;
      repeat (n) tick();
      rst = 1'b1;
   endtask

   task automatic send(input logic [63:0] m);
      int n;
      n = 0;
      msg_data = m;
      msg_valid = 1'b1;
      @(negedge clk);
      while (msg_ready !== 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: msg_ready=%b, expected 1 within 200 cycles", msg_ready);
         msg_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #2;
      msg_valid = 1'b0;
      exp_q.push_back(model(m, exp_phase));
      exp_phase = (exp_phase + STEP) % 16;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d outputs pending, expected 0", exp_q.size());
         exp_q.delete();
      end
      tick();
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (y_valid !== 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (y_valid !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s: y_valid=%b, expected 1 within 50 cycles", name, y_valid);
      end
   endtask

   // Fixed latency with y_ready=1: CALC on the first negedge, HOLD on the second.
   task automatic wait_out(input string name, input logic [63:0] yexp, input logic satexp);
      @(negedge clk);
      check({name, "_calc_valid"}, 64'(y_valid), 64'(0));
      check({name, "_calc_ready"}, 64'(msg_ready), 64'(0));
      @(negedge clk);
      check({name, "_valid"}, 64'(y_valid), 64'(1));
      check({name, "_y"}, y, yexp);
      check({name, "_sat"}, 64'(sat), 64'(satexp));
   endtask

   logic [63:0] ext [4];
   logic [63:0] m;

   initial begin
      ext[0] = 64'h7FFFFFFF_FFFFFFFF;
      ext[1] = 64'h80000000_00000000;
      ext[2] = 64'hFFFFFFFF_FFFFFFFF;
      ext[3] = 64'h00000000_00000000;

      // Reset held for two cycles
      repeat (2) tick();
      @(negedge clk);
      check("reset_msg_ready", 64'(msg_ready), 64'(0));
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("reset_y", y, 64'h0);
      check("reset_y_valid", 64'(y_valid), 64'(0));
      check("reset_sat", 64'(sat), 64'(0));
      check("reset_phase", 64'(phase), 64'(0));
      check("reset_msg_ready_after", 64'(msg_ready), 64'(1));
      tick();

      // Basic 0.5 at phase 0
      y_ready = 1'b1;
      send(64'h00000000_80000000);
      wait_out("basic", 64'h00000001_80000000, 1'b0);
      drain();
      check("basic_phase", 64'(phase), 64'(1));

      // Sweep through the whole table and wrap
      do_reset(2);
      for (int i = 0; i < 17; i++) send(64'h0);
      drain();
      check("sweep_phase", 64'(phase), 64'(1));

      // Backpressure with msg_valid held in HOLD
      do_reset(1);
      y_ready = 1'b0;
      send(64'h00000002_40000000);
      wait_valid("bp_valid");
      tick();
      msg_data = 64'h00000000_12345678;
      msg_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_msg_ready", 64'(msg_ready), 64'(0));
         check("bp_y_valid", 64'(y_valid), 64'(1));
      end
      tick();
      y_ready = 1'b1;
      msg_valid = 1'b0;
      tick();
      y_ready = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("bp_after_valid", 64'(y_valid), 64'(0));
      check("bp_pending", 64'(exp_q.size()), 64'(0));
      check("bp_phase", 64'(phase), 64'(1));
      tick();

      // Saturation at both limits and the phase-8 negation
      do_reset(1);
      y_ready = 1'b1;
      send(64'h7FFFFFFF_FFFFFFFF);
      wait_out("sat_pos", 64'h7FFFFFFF_FFFFFFFF, 1'b1);
      drain();
      while (exp_phase != 8) send(64'h0);
      drain();
      send(64'h80000000_00000000);
      wait_out("sat_ph8", 64'h7FFFFFFF_00000000, 1'b0);
      drain();
      while (exp_phase != 8) send(64'h0);
      drain();
      send(64'h7FFFFFFF_FFFFFFFF);
      wait_out("sat_neg", 64'h80000000_00000000, 1'b1);
      drain();

      // Reset during HOLD discards the pending sample
      do_reset(1);
      y_ready = 1'b1;
      for (int i = 0; i < 5; i++) send(64'h0);
      drain();
      y_ready = 1'b0;
      send(64'h00000003_00000000);
      wait_valid("mid_valid");
      check("mid_phase_before", 64'(phase), 64'(5));
      tick();
      rst = 1'b0;
      exp_q.delete();
      exp_phase = 0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("mid_y_valid", 64'(y_valid), 64'(0));
      check("mid_y", y, 64'h0);
      check("mid_phase", 64'(phase), 64'(0));
      check("mid_msg_ready", 64'(msg_ready), 64'(1));
      tick();
      y_ready = 1'b1;
      send(64'h0);
      wait_out("mid_next", 64'h00000001_00000000, 1'b0);
      drain();

      // Random traffic with random backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 3))
            0: m = {$urandom, $urandom};
            1: m = {{32{1'($urandom_range(0, 1))}}, 32'($urandom)};
            2: m = ext[$urandom_range(0, 3)];
            default: m = {30'($urandom_range(0, 7)) << 0, 2'b00, 32'($urandom)};
         endcase
         send(m);
         repeat ($urandom_range(0, 2)) tick();
      end
      rand_ready = 1'b0;
      tick();
      y_ready = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
